// File: rtl/cpu_controller_pkg.sv
// rtl/cpu_controller_pkg.sv - opcode, sub-op, state constants and decode types for cpu_controller
// Contents:
//   ST_*      controller state encodings
//   OP_*      primary opcodes, instruction[30:25]
//   SUB_*     TY_BASE sub-ops (instruction[4:0]) and TY_LS sub-ops (instruction[7:0])
//   BR_*      branch selector carried in instruction[14] of TY_B
//   fields_t  decoded fields handed to the datapath
//   class_t   instruction class flags used by the sequencer
package cpu_controller_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEMORY    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;

    localparam logic [5:0] OP_TY_BASE = 6'b100000;
    localparam logic [5:0] OP_ADDI    = 6'b101000;
    localparam logic [5:0] OP_ORI     = 6'b101100;
    localparam logic [5:0] OP_XORI    = 6'b101011;
    localparam logic [5:0] OP_MOVI    = 6'b100010;
    localparam logic [5:0] OP_LWI     = 6'b000010;
    localparam logic [5:0] OP_SWI     = 6'b001010;
    localparam logic [5:0] OP_TY_LS   = 6'b011100;
    localparam logic [5:0] OP_TY_B    = 6'b100110;
    localparam logic [5:0] OP_JJ      = 6'b100100;

    localparam logic [4:0] SUB_ADD   = 5'h00;
    localparam logic [4:0] SUB_SUB   = 5'h01;
    localparam logic [4:0] SUB_AND   = 5'h02;
    localparam logic [4:0] SUB_XOR   = 5'h03;
    localparam logic [4:0] SUB_OR    = 5'h04;
    localparam logic [4:0] SUB_SLLI  = 5'h08;
    localparam logic [4:0] SUB_SRLI  = 5'h09;
    localparam logic [4:0] SUB_ROTRI = 5'h0B;

    localparam logic [7:0] SUB_LW = 8'h02;
    localparam logic [7:0] SUB_SW = 8'h0A;

    localparam logic BR_BEQ = 1'b0;
    localparam logic BR_BNE = 1'b1;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  sub_op_base;
        logic [7:0]  sub_op_ls;
        logic [4:0]  read_addr1;
        logic [4:0]  read_addr2;
        logic [4:0]  write_addr;
        logic [31:0] imm_ext;
        logic [31:0] pc_offset;
        logic        select_imm;
    } fields_t;

    typedef struct packed {
        logic is_alu;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic is_illegal;
    } class_t;

endpackage

// File: rtl/cpu_controller_inst_decoder.sv
// rtl/cpu_controller_inst_decoder.sv - combinational instruction decoder for cpu_controller
// Ports:
//   inst    in   32  instruction word to decode
//   fields  out  fields_t  register addresses, sub-ops, immediates, pc offset, select_imm
//   cls     out  class_t   alu/load/store/branch/jump/illegal flags (exactly one set)
module cpu_controller_inst_decoder
    import cpu_controller_pkg::*;
(
    input  logic [31:0] inst,
    output fields_t     fields,
    output class_t      cls
);

    logic [5:0]  op;
    logic        base_shift;
    logic        base_ok;
    logic        ls_ok;
    logic [31:0] sext15;
    logic [31:0] zext15;
    logic        unused_msb;

    assign op         = inst[30:25];
    assign sext15     = {{17{inst[14]}}, inst[14:0]};
    assign zext15     = {17'b0, inst[14:0]};
    // bit 31 selects the 16/32-bit format elsewhere in the core; this unit only sees 32-bit words
    assign unused_msb = inst[31];

    always_comb begin
        base_shift = (inst[4:0] == SUB_SLLI) || (inst[4:0] == SUB_SRLI) ||
                     (inst[4:0] == SUB_ROTRI);
        base_ok    = base_shift || (inst[4:0] == SUB_ADD) || (inst[4:0] == SUB_SUB) ||
                     (inst[4:0] == SUB_AND) || (inst[4:0] == SUB_XOR) ||
                     (inst[4:0] == SUB_OR);
        ls_ok      = (inst[7:0] == SUB_LW) || (inst[7:0] == SUB_SW);

        fields.opcode      = op;
        fields.sub_op_base = inst[4:0];
        fields.sub_op_ls   = inst[7:0];
        fields.read_addr1  = inst[19:15];
        fields.read_addr2  = inst[14:10];
        fields.write_addr  = inst[24:20];
        fields.imm_ext     = '0;
        fields.pc_offset   = '0;
        fields.select_imm  = 1'b0;
        cls                = '0;

        case (op)
            OP_TY_BASE: begin
                cls.is_alu     = base_ok;
                cls.is_illegal = !base_ok;
                if (base_shift) begin
                    fields.imm_ext    = {27'b0, inst[14:10]};
                    fields.select_imm = 1'b1;
                end
            end
            OP_ADDI: begin
                cls.is_alu        = 1'b1;
                fields.imm_ext    = sext15;
                fields.select_imm = 1'b1;
            end
            OP_ORI, OP_XORI: begin
                cls.is_alu        = 1'b1;
                fields.imm_ext    = zext15;
                fields.select_imm = 1'b1;
            end
            OP_MOVI: begin
                cls.is_alu        = 1'b1;
                fields.imm_ext    = {{12{inst[19]}}, inst[19:0]};
                fields.select_imm = 1'b1;
            end
            OP_LWI: begin
                cls.is_load       = 1'b1;
                fields.imm_ext    = sext15;
                fields.select_imm = 1'b1;
            end
            OP_SWI: begin
                cls.is_store      = 1'b1;
                fields.imm_ext    = sext15;
                fields.select_imm = 1'b1;
            end
            OP_TY_LS: begin
                cls.is_load    = (inst[7:0] == SUB_LW);
                cls.is_store   = (inst[7:0] == SUB_SW);
                cls.is_illegal = !ls_ok;
            end
            OP_TY_B: begin
                cls.is_branch    = 1'b1;
                fields.pc_offset = {{17{inst[13]}}, inst[13:0], 1'b0};
            end
            OP_JJ: begin
                cls.is_jump      = 1'b1;
                fields.pc_offset = {{7{inst[23]}}, inst[23:0], 1'b0};
            end
            default: begin
                cls.is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control unit
// Ports:
//   clk, reset (async, active-high)
//   instruction[31:0]  in   instruction-memory data, captured at the end of FETCH
//   alu_zero           in   ALU zero flag, sampled at the end of EXECUTE
//   mem_ready          in   data-memory completion, only looked at in MEMORY
//   enable_fetch/execute/mem_read/mem_write/writeback/pc, pc_branch   out strobes
//   pc_offset, opcode, sub_op_base, sub_op_ls, read_addr1/2, write_addr,
//   imm_ext, select_imm, wb_select_mem, illegal_inst                   out decoded fields
// Every output is a flop. PC updates that depend on a value sampled at the end of a state
// (branch outcome, store completion) therefore appear in the first cycle of the next FETCH.
module cpu_controller
    import cpu_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        enable_fetch,
    output logic        enable_execute,
    output logic        enable_mem_read,
    output logic        enable_mem_write,
    output logic        enable_writeback,
    output logic        enable_pc,
    output logic        pc_branch,
    output logic [31:0] pc_offset,
    output logic [5:0]  opcode,
    output logic [4:0]  sub_op_base,
    output logic [7:0]  sub_op_ls,
    output logic [4:0]  read_addr1,
    output logic [4:0]  read_addr2,
    output logic [4:0]  write_addr,
    output logic [31:0] imm_ext,
    output logic        select_imm,
    output logic        wb_select_mem,
    output logic        illegal_inst
);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [31:0] ir;
    logic [31:0] dec_in;
    fields_t     dec_fields;
    fields_t     fields_q;
    class_t      dec_cls;
    class_t      cls;
    logic        taken;

    // Decode the word being captured so the fields are already registered while in DECODE.
    assign dec_in = (state == ST_FETCH) ? instruction : ir;

    cpu_controller_inst_decoder inst_decoder (
        .inst   (dec_in),
        .fields (dec_fields),
        .cls    (dec_cls)
    );

    assign taken = cls.is_branch &&
                   (((ir[14] == BR_BEQ) && alu_zero) || ((ir[14] == BR_BNE) && !alu_zero));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      state_next = ST_FETCH;
            ST_FETCH:     state_next = ST_DECODE;
            ST_DECODE:    state_next = cls.is_illegal ? ST_FETCH : ST_EXECUTE;
            ST_EXECUTE: begin
                if (cls.is_load || cls.is_store) state_next = ST_MEMORY;
                else if (cls.is_alu)             state_next = ST_WRITEBACK;
                else                             state_next = ST_FETCH;
            end
            ST_MEMORY: begin
                if (mem_ready) state_next = cls.is_load ? ST_WRITEBACK : ST_FETCH;
            end
            ST_WRITEBACK: state_next = ST_FETCH;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            ir               <= '0;
            fields_q         <= '0;
            cls              <= '0;
            enable_fetch     <= 1'b0;
            enable_execute   <= 1'b0;
            enable_mem_read  <= 1'b0;
            enable_mem_write <= 1'b0;
            enable_writeback <= 1'b0;
            enable_pc        <= 1'b0;
            pc_branch        <= 1'b0;
            wb_select_mem    <= 1'b0;
            illegal_inst     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH) begin
                ir       <= instruction;
                fields_q <= dec_fields;
                cls      <= dec_cls;
            end
            enable_fetch     <= (state_next == ST_FETCH);
            enable_execute   <= (state_next == ST_EXECUTE) && !cls.is_jump;
            enable_mem_read  <= (state_next == ST_MEMORY) && cls.is_load;
            enable_mem_write <= (state_next == ST_MEMORY) && cls.is_store;
            enable_writeback <= (state_next == ST_WRITEBACK);
            wb_select_mem    <= (state_next == ST_WRITEBACK) && cls.is_load;
            illegal_inst     <= (state == ST_FETCH) && dec_cls.is_illegal;
            enable_pc        <= ((state == ST_FETCH) && dec_cls.is_illegal) ||
                                ((state == ST_EXECUTE) && (cls.is_branch || cls.is_jump)) ||
                                ((state == ST_MEMORY) && mem_ready && cls.is_store) ||
                                (state_next == ST_WRITEBACK);
            pc_branch        <= (state == ST_EXECUTE) && (cls.is_jump || taken);
        end
    end

    assign opcode      = fields_q.opcode;
    assign sub_op_base = fields_q.sub_op_base;
    assign sub_op_ls   = fields_q.sub_op_ls;
    assign read_addr1  = fields_q.read_addr1;
    assign read_addr2  = fields_q.read_addr2;
    assign write_addr  = fields_q.write_addr;
    assign imm_ext     = fields_q.imm_ext;
    assign pc_offset   = fields_q.pc_offset;
    assign select_imm  = fields_q.select_imm;

endmodule
